// File: rtl/flag_branch_unit.sv
// flag_branch_unit: Z/V/N flag register plus conditional branch resolution.
// Registers the ALU flag bus {Z,V,N}, evaluates B/BR conditions with
// same-cycle flag bypass, and issues a registered one-cycle PC redirect
// and flush. REDIRECT ignores the wrong-path slot behind a taken branch.
// Optional feature macro: FLAG_BRANCH_STATS_EN (saturating taken/not-taken
// counters); when undefined both statistic outputs read zero.
module flag_branch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flags_valid,
  input  logic [2:0]  flags_in,
  input  logic        flag_pend,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic        br_is_reg,
  input  logic [2:0]  br_cond,
  input  logic [15:0] br_pc_plus2,
  input  logic [8:0]  br_imm,
  input  logic [15:0] br_reg_target,
  output logic [2:0]  flags_out,
  output logic        redirect_valid,
  output logic [15:0] redirect_pc,
  output logic        flush,
  output logic [15:0] stat_taken,
  output logic [15:0] stat_not_taken
);

  localparam int unsigned DW = 16;

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t          state;
  logic [2:0]      flag_q;
  logic [2:0]      eff_flags_c;
  logic            flag_z_c;
  logic            flag_v_c;
  logic            flag_n_c;
  logic            cond_true_c;
  logic            br_accept_c;
  logic [DW-1:0]   target_c;

  // Ready only in IDLE with no pending flag writer, and never while in reset
  assign br_ready = rst_n & (state == IDLE) & ~flag_pend;
  assign br_accept_c = br_valid & br_ready;

  // Same-cycle ALU flags take precedence over the stored register
  assign eff_flags_c = flags_valid ? flags_in : flag_q;
  assign flag_z_c    = eff_flags_c[2];
  assign flag_v_c    = eff_flags_c[1];
  assign flag_n_c    = eff_flags_c[0];

  // Condition code decode against the effective flags
  always_comb begin
    cond_true_c = 1'b0;
    case (br_cond)
      3'b000:  cond_true_c = ~flag_z_c;
      3'b001:  cond_true_c = flag_z_c;
      3'b010:  cond_true_c = ~flag_z_c & ~flag_n_c;
      3'b011:  cond_true_c = flag_n_c;
      3'b100:  cond_true_c = flag_z_c | (~flag_z_c & ~flag_n_c);
      3'b101:  cond_true_c = flag_n_c | flag_z_c;
      3'b110:  cond_true_c = flag_v_c;
      default: cond_true_c = 1'b1;
    endcase
  end

  // Branch target: sign-extended word offset scaled to bytes, wraps mod 2^16
  assign target_c = br_is_reg ? br_reg_target
                              : DW'(br_pc_plus2 + {{6{br_imm[8]}}, br_imm, 1'b0});

  assign flags_out = flag_q;

  // Flag register, branch FSM and registered redirect outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      flag_q         <= 3'b000;
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      case (state)
        IDLE: begin
          if (flags_valid) flag_q <= flags_in;
          if (br_accept_c && cond_true_c) begin
            state          <= REDIRECT;
            redirect_valid <= 1'b1;
            flush          <= 1'b1;
            redirect_pc    <= target_c;
          end
        end
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

`ifdef FLAG_BRANCH_STATS_EN
  logic [DW-1:0] taken_q;
  logic [DW-1:0] not_taken_q;

  // Saturating per-outcome counters of accepted branches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_q     <= '0;
      not_taken_q <= '0;
    end else if (br_accept_c) begin
      if (cond_true_c) begin
        if (taken_q != 16'hFFFF) taken_q <= taken_q + DW'(1);
      end else begin
        if (not_taken_q != 16'hFFFF) not_taken_q <= not_taken_q + DW'(1);
      end
    end
  end

  assign stat_taken     = taken_q;
  assign stat_not_taken = not_taken_q;
`else
  assign stat_taken     = 16'h0000;
  assign stat_not_taken = 16'h0000;
`endif

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Holds the processor's Z/V/N flag register and resolves conditional branches against it. Sits beside the ALU: it registers the `{Z,V,N}` flag bus the ALU produces and reads it back for B/BR instructions. It drives a registered PC redirect and flush to fetch/decode. It also owns the one-cycle wrong-path shadow after a taken branch.

## Interface
- no parameters; data width is fixed at 16 bits
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `flags_valid`  in  1  ALU flag bus valid this cycle
- `flags_in`  in  3  ALU flag bus, `{Z,V,N}`
- `flag_pend`  in  1  a flag-writing instruction is in flight but not yet at the ALU
- `br_valid`  in  1  branch request
- `br_ready`  out  1  unit can accept a branch this cycle
- `br_is_reg`  in  1  0 = B (PC-relative), 1 = BR (register target)
- `br_cond`  in  3  condition code
- `br_pc_plus2`  in  16  address of the branch + 2
- `br_imm`  in  9  signed word offset
- `br_reg_target`  in  16  register target for BR
- `flags_out`  out  3  current flag register `{Z,V,N}`
- `redirect_valid`  out  1  load `redirect_pc` into the PC
- `redirect_pc`  out  16  branch target
- `flush`  out  1  squash the instruction fetched after the branch
- `stat_taken`, `stat_not_taken`  out  16 each  branch statistics (see Configuration)

## Operation
- The flag register is written when `flags_valid=1` and the state is IDLE. It is never written in REDIRECT.
- A branch is accepted on `br_valid & br_ready`.
- `br_ready = (state==IDLE) & ~flag_pend`.
- Effective flags for evaluation:
  - `flags_in` when `flags_valid=1` in the same cycle (bypass),
  - otherwise the flag register.
- Conditions on `{Z,V,N}`:
  - 000: Z=0
  - 001: Z=1
  - 010: Z=0 & N=0
  - 011: N=1
  - 100: Z=1 | (Z=0 & N=0)
  - 101: N=1 | Z=1
  - 110: V=1
  - 111: always
- Target computation:
  - B: `br_pc_plus2 + ({{7{br_imm[8]}},br_imm} << 1)`, 16-bit, wrapping modulo 2^16 with no saturation.
  - BR: `br_reg_target`.
- FSM with two states:
  - IDLE: an accepted taken branch moves the FSM to REDIRECT. A not-taken branch stays in IDLE with no output pulse.
  - REDIRECT: lasts exactly one cycle, then returns to IDLE unconditionally. `br_valid` is ignored, and `flags_valid` is ignored because it carries wrong-path flags.

## Timing
- Reset values:
  - flag register, `flags_out` = 3'b000
  - `redirect_valid`, `flush` = 0
  - `redirect_pc` = 16'h0000
  - `br_ready` = 0 while `rst_n`=0
  - state = IDLE
  - stat counters = 0
- Latency from an accepted taken branch at edge N: `redirect_valid` and `flush` are high for one cycle after edge N, with `redirect_pc` valid in that cycle. `redirect_pc` holds its value otherwise.
- `flags_out` updates one cycle after the `flags_valid` edge.
- `br_ready` is combinational from `flag_pend` and state. The requester holds `br_valid` and its fields stable until accepted.
- Back-to-back branches:
  - A branch in the cycle after a taken branch is not accepted (REDIRECT).
  - A branch after a not-taken branch is accepted immediately.
- Simultaneous `flags_valid` and an accepted branch in IDLE: the branch uses the new flags, and the register also updates.
- `flag_pend=1` with `flags_valid=1`: the flags are still written and the branch stalls.
- If `rst_n` falls during REDIRECT, all outputs clear immediately and the pending redirect is lost.

## Configuration
- Macro: `FLAG_BRANCH_STATS_EN`.
- Defined:
  - `stat_taken` and `stat_not_taken` are 16-bit counters.
  - Each increments by 1 per accepted branch of its kind.
  - Each saturates at 16'hFFFF; there is no wrap.
- Undefined: both outputs are tied to 16'h0000 and no counter flops exist.

## Test plan
- Reset, then write flags `{Z,V,N}`=3'b100 and issue B with cond 001, pc_plus2=16'h0010, imm=9'h003. Expect one cycle of `redirect_valid`=`flush`=1 with `redirect_pc`=16'h0016, then IDLE.
- B with cond 000 and Z=1. Expect no redirect, `br_ready` staying 1, and `stat_not_taken` incrementing.
- Negative offset and wrap:
  - pc_plus2=16'h0002, imm=9'h1FF, cond 111: `redirect_pc`=16'h0000.
  - pc_plus2=16'hFFFE, imm=9'h001: `redirect_pc`=16'h0000.
- Same-cycle `flags_valid` with `flags_in`=3'b001 and BR cond 011 to 16'hABCD: taken via bypass, `redirect_pc`=16'hABCD, and `flags_out`=3'b001 next cycle.
- `flag_pend`=1 held 3 cycles with `br_valid`=1: `br_ready`=0 throughout. Drop `flag_pend`: accepted that cycle.
- Taken branch followed by `flags_valid`=1 (3'b010) and `br_valid` in the REDIRECT cycle: flags unchanged and the branch is not accepted. Assert `rst_n`=0 during a REDIRECT: `redirect_valid` goes low immediately.
